ysyx_220066_id_ex_issue: RTL and testbench

ID/EX issue register for the ysyx_220066 core, one entry deep, with a valid/ready handshake on each side. It captures a decoded instruction, resolves register operands by forwarding from EX, MEM and WB, and holds the instruction while a load-use hazard is pending. It then presents final operands and the 5-bit ALU control directly to the ALU.

---
 rtl/ysyx_220066_id_ex_issue_pkg.sv | 16 +
 rtl/ysyx_220066_id_ex_issue_if.sv | 66 ++++++
 rtl/ysyx_220066_fwd_sel.sv | 44 ++++
 rtl/ysyx_220066_id_ex_issue.sv | 135 +++++++++++++
 tb/tb_ysyx_220066_id_ex_issue.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_220066_id_ex_issue_pkg.sv
// Shared definitions for the ID/EX issue register: widths, x0 index, FSM states.
package ysyx_220066_id_ex_issue_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned REG_W    = 5;
   localparam int unsigned ALUCTR_W = 5;

   localparam logic [REG_W-1:0] X0 = 5'd0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } state_e;

endpackage

// File: rtl/ysyx_220066_id_ex_issue_if.sv
// Bundle of decode-side, bypass and ALU-side signals around the ID/EX issue register.
interface ysyx_220066_id_ex_issue_if;
   import ysyx_220066_id_ex_issue_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [XLEN-1:0]     in_pc;
   logic [XLEN-1:0]     in_imm;
   logic [REG_W-1:0]    in_rs1;
   logic [REG_W-1:0]    in_rs2;
   logic [REG_W-1:0]    in_rd;
   logic [XLEN-1:0]     in_rs1_data;
   logic [XLEN-1:0]     in_rs2_data;
   logic                in_src_a_pc;
   logic                in_src_b_imm;
   logic [ALUCTR_W-1:0] in_aluctr;
   logic                in_rd_wen;
   logic                in_is_load;

   logic                flush;
   logic [XLEN-1:0]     alu_result;

   logic                mem_valid;
   logic                mem_rd_wen;
   logic                mem_is_load;
   logic [REG_W-1:0]    mem_rd;
   logic [XLEN-1:0]     mem_data;

   logic                wb_valid;
   logic                wb_rd_wen;
   logic [REG_W-1:0]    wb_rd;
   logic [XLEN-1:0]     wb_data;

   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_data_a;
   logic [XLEN-1:0]     out_data_b;
   logic [ALUCTR_W-1:0] out_aluctr;
   logic [XLEN-1:0]     out_pc;
   logic [REG_W-1:0]    out_rd;
   logic                out_rd_wen;
   logic                out_is_load;

   // Pipeline surroundings drive this side.
   modport master (
      output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
             in_src_a_pc, in_src_b_imm, in_aluctr, in_rd_wen, in_is_load,
             flush, alu_result,
             mem_valid, mem_rd_wen, mem_is_load, mem_rd, mem_data,
             wb_valid, wb_rd_wen, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, out_data_a, out_data_b, out_aluctr, out_pc, out_rd,
             out_rd_wen, out_is_load
   );

   // The issue register itself.
   modport slave (
      input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
             in_src_a_pc, in_src_b_imm, in_aluctr, in_rd_wen, in_is_load,
             flush, alu_result,
             mem_valid, mem_rd_wen, mem_is_load, mem_rd, mem_data,
             wb_valid, wb_rd_wen, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, out_data_a, out_data_b, out_aluctr, out_pc, out_rd,
             out_rd_wen, out_is_load
   );

endinterface

// File: rtl/ysyx_220066_fwd_sel.sv
// Per-operand bypass select: EX > MEM > WB > register file, x0 hard-wired to zero.
module ysyx_220066_fwd_sel
   import ysyx_220066_id_ex_issue_pkg::*;
(
   input  logic [REG_W-1:0] rs,
   input  logic [XLEN-1:0]  rf_data,
   input  logic             ex_en,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_is_load,
   input  logic [XLEN-1:0]  ex_data,
   input  logic             mem_en,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_is_load,
   input  logic [XLEN-1:0]  mem_data,
   input  logic             wb_en,
   input  logic [REG_W-1:0] wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic [XLEN-1:0]  value,
   output logic             pending,
   output logic             hit
);

   // Priority-ordered match; a load producer leaves the operand pending.
   always_comb begin
      value   = rf_data;
      pending = 1'b0;
      hit     = 1'b0;
      if (rs == X0) begin
         value = '0;
      end else if (ex_en && ex_rd == rs) begin
         hit     = 1'b1;
         value   = ex_data;
         pending = ex_is_load;
      end else if (mem_en && mem_rd == rs) begin
         hit     = 1'b1;
         value   = mem_data;
         pending = mem_is_load;
      end else if (wb_en && wb_rd == rs) begin
         hit   = 1'b1;
         value = wb_data;
      end
   end

endmodule

// File: rtl/ysyx_220066_id_ex_issue.sv
// One-entry ID/EX issue register with operand forwarding and load-use hold.
module ysyx_220066_id_ex_issue
   import ysyx_220066_id_ex_issue_pkg::*;
(
   input logic                       clk,
   input logic                       rst,
   ysyx_220066_id_ex_issue_if.slave  bus
);

   state_e           state_q, state_d;
   logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
   logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic [REG_W-1:0] rs_a_q, rs_b_q;
   logic             fire, capture, in_ready;
   logic [XLEN-1:0]  fa_value, fb_value;
   logic             fa_pending, fb_pending, fa_hit, fb_hit;
   logic             mem_en, wb_en;

   assign fire     = (state_q == READY) && bus.out_ready;
   assign in_ready = ((state_q == EMPTY) || fire) && !bus.flush;
   assign capture  = bus.in_valid && in_ready;
   assign mem_en   = bus.mem_valid && bus.mem_rd_wen;
   assign wb_en    = bus.wb_valid && bus.wb_rd_wen;

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = (state_q == READY);
   assign bus.out_data_a = a_q;
   assign bus.out_data_b = b_q;

   // In WAIT nothing fires, so the EX path is idle and only MEM/WB can resolve.
   ysyx_220066_fwd_sel u_fwd_a (
      .rs          ((state_q == WAIT) ? rs_a_q : bus.in_rs1),
      .rf_data     (bus.in_rs1_data),
      .ex_en       (fire && bus.out_rd_wen),
      .ex_rd       (bus.out_rd),
      .ex_is_load  (bus.out_is_load),
      .ex_data     (bus.alu_result),
      .mem_en      (mem_en),
      .mem_rd      (bus.mem_rd),
      .mem_is_load (bus.mem_is_load),
      .mem_data    (bus.mem_data),
      .wb_en       (wb_en),
      .wb_rd       (bus.wb_rd),
      .wb_data     (bus.wb_data),
      .value       (fa_value),
      .pending     (fa_pending),
      .hit         (fa_hit)
   );

   ysyx_220066_fwd_sel u_fwd_b (
      .rs          ((state_q == WAIT) ? rs_b_q : bus.in_rs2),
      .rf_data     (bus.in_rs2_data),
      .ex_en       (fire && bus.out_rd_wen),
      .ex_rd       (bus.out_rd),
      .ex_is_load  (bus.out_is_load),
      .ex_data     (bus.alu_result),
      .mem_en      (mem_en),
      .mem_rd      (bus.mem_rd),
      .mem_is_load (bus.mem_is_load),
      .mem_data    (bus.mem_data),
      .wb_en       (wb_en),
      .wb_rd       (bus.wb_rd),
      .wb_data     (bus.wb_data),
      .value       (fb_value),
      .pending     (fb_pending),
      .hit         (fb_hit)
   );

   // Next state and operand updates; flush beats capture and forwarding.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      pend_a_d = pend_a_q;
      pend_b_d = pend_b_q;
      if (bus.flush) begin
         state_d  = EMPTY;
         pend_a_d = 1'b0;
         pend_b_d = 1'b0;
      end else if (capture) begin
         a_d      = bus.in_src_a_pc ? bus.in_pc : fa_value;
         b_d      = bus.in_src_b_imm ? bus.in_imm : fb_value;
         pend_a_d = !bus.in_src_a_pc && fa_pending;
         pend_b_d = !bus.in_src_b_imm && fb_pending;
         state_d  = (pend_a_d || pend_b_d) ? WAIT : READY;
      end else if (state_q == WAIT) begin
         // A load match keeps the bit set; any other match resolves it.
         if (pend_a_q && fa_hit && !fa_pending) begin
            a_d      = fa_value;
            pend_a_d = 1'b0;
         end
         if (pend_b_q && fb_hit && !fb_pending) begin
            b_d      = fb_value;
            pend_b_d = 1'b0;
         end
         state_d = (pend_a_d || pend_b_d) ? WAIT : READY;
      end else if (fire) begin
         state_d = EMPTY;
      end
   end

   // State, operands and captured control fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= EMPTY;
         a_q             <= '0;
         b_q             <= '0;
         pend_a_q        <= 1'b0;
         pend_b_q        <= 1'b0;
         rs_a_q          <= '0;
         rs_b_q          <= '0;
         bus.out_aluctr  <= '0;
         bus.out_pc      <= '0;
         bus.out_rd      <= '0;
         bus.out_rd_wen  <= 1'b0;
         bus.out_is_load <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         pend_a_q <= pend_a_d;
         pend_b_q <= pend_b_d;
         if (capture) begin
            rs_a_q          <= bus.in_rs1;
            rs_b_q          <= bus.in_rs2;
            bus.out_aluctr  <= bus.in_aluctr;
            bus.out_pc      <= bus.in_pc;
            bus.out_rd      <= bus.in_rd;
            bus.out_rd_wen  <= bus.in_rd_wen;
            bus.out_is_load <= bus.in_is_load;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_220066_id_ex_issue.sv
// Directed bench for the ID/EX issue register: forwarding, load-use hold, flush, reset.
module tb_ysyx_220066_id_ex_issue;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   ysyx_220066_id_ex_issue_if bus ();

   ysyx_220066_id_ex_issue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.in_valid     = 0;
      bus.in_pc        = '0;
      bus.in_imm       = '0;
      bus.in_rs1       = '0;
      bus.in_rs2       = '0;
      bus.in_rd        = '0;
      bus.in_rs1_data  = '0;
      bus.in_rs2_data  = '0;
      bus.in_src_a_pc  = 0;
      bus.in_src_b_imm = 0;
      bus.in_aluctr    = '0;
      bus.in_rd_wen    = 0;
      bus.in_is_load   = 0;
      bus.mem_valid    = 0;
      bus.mem_rd_wen   = 0;
      bus.mem_is_load  = 0;
      bus.mem_rd       = '0;
      bus.mem_data     = '0;
      bus.wb_valid     = 0;
      bus.wb_rd_wen    = 0;
      bus.wb_rd        = '0;
      bus.wb_data      = '0;
   endtask

   initial begin
      clear_in();
      bus.flush      = 0;
      bus.alu_result = '0;
      bus.out_ready  = 0;
      #1;
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_a", bus.out_data_a, 64'd0);
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(negedge clk);
      rst = 0;
      #1;

      // Independent add
      bus.in_valid = 1; bus.in_pc = 64'h8000_0000;
      bus.in_rs1 = 3; bus.in_rs1_data = 64'h10;
      bus.in_rs2 = 4; bus.in_rs2_data = 64'h20;
      bus.in_rd = 5; bus.in_rd_wen = 1; bus.in_aluctr = 0;
      tick();
      chk("add_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("add_a", bus.out_data_a, 64'h10);
      chk("add_b", bus.out_data_b, 64'h20);
      chk("add_aluctr", {59'd0, bus.out_aluctr}, 64'd0);
      chk("add_pc", bus.out_pc, 64'h8000_0000);
      clear_in();
      bus.in_valid = 1; bus.in_rs1 = 8; bus.in_rs1_data = 64'h33;
      #1;
      chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
      chk("hold_a", bus.out_data_a, 64'h10);
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);

      // EX forward: held rd=5 fires while rs1=5 is captured
      clear_in();
      bus.out_ready = 1; bus.alu_result = 64'hAB;
      bus.in_valid = 1; bus.in_pc = 64'h8000_0004;
      bus.in_rs1 = 5; bus.in_rs1_data = 64'h55;
      bus.in_src_b_imm = 1; bus.in_imm = 64'h7;
      bus.in_rd = 6; bus.in_rd_wen = 1; bus.in_aluctr = 3;
      #1;
      chk("fire_in_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
      chk("ex_fwd_a", bus.out_data_a, 64'hAB);
      chk("ex_fwd_b_imm", bus.out_data_b, 64'h7);
      chk("ex_fwd_aluctr", {59'd0, bus.out_aluctr}, 64'd3);

      // MEM beats WB for the same register
      clear_in();
      bus.in_valid = 1; bus.in_rs1 = 7; bus.in_rs2 = 7;
      bus.in_rs1_data = 64'h99; bus.in_rs2_data = 64'h99; bus.in_rd = 8;
      bus.mem_valid = 1; bus.mem_rd_wen = 1; bus.mem_rd = 7; bus.mem_data = 64'h1;
      bus.wb_valid = 1; bus.wb_rd_wen = 1; bus.wb_rd = 7; bus.wb_data = 64'h2;
      tick();
      chk("mem_prio_a", bus.out_data_a, 64'h1);
      chk("mem_prio_b", bus.out_data_b, 64'h1);

      // Load to x9 enters the register
      clear_in();
      bus.in_valid = 1; bus.in_rs1 = 1; bus.in_rs1_data = 64'h100;
      bus.in_src_b_imm = 1; bus.in_imm = 64'h8;
      bus.in_rd = 9; bus.in_rd_wen = 1; bus.in_is_load = 1;
      tick();
      chk("ld_is_load", {63'd0, bus.out_is_load}, 64'd1);
      chk("ld_a", bus.out_data_a, 64'h100);

      // Dependent on the load: two bubbles then ready
      clear_in();
      bus.alu_result = 64'h1234;
      bus.in_valid = 1; bus.in_rs1 = 2; bus.in_rs1_data = 64'h22;
      bus.in_rs2 = 9; bus.in_rs2_data = 64'h5;
      bus.in_rd = 10; bus.in_rd_wen = 0; bus.in_aluctr = 1;
      tick();
      chk("lu_c1_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("lu_c1_in_ready", {63'd0, bus.in_ready}, 64'd0);
      clear_in();
      bus.mem_valid = 1; bus.mem_rd_wen = 1; bus.mem_is_load = 1;
      bus.mem_rd = 9; bus.mem_data = 64'h1234;
      tick();
      chk("lu_c2_valid", {63'd0, bus.out_valid}, 64'd0);
      clear_in();
      bus.wb_valid = 1; bus.wb_rd_wen = 1; bus.wb_rd = 9; bus.wb_data = 64'hDEAD;
      tick();
      chk("lu_c3_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("lu_b", bus.out_data_b, 64'hDEAD);
      chk("lu_a", bus.out_data_a, 64'h22);
      chk("lu_rd", {59'd0, bus.out_rd}, 64'd10);

      // x0 never forwarded; this entry is a load to x11 for the flush test
      clear_in();
      bus.in_valid = 1; bus.in_rs1 = 0; bus.in_rs1_data = 64'h77;
      bus.in_rs2 = 0; bus.in_rs2_data = 64'h77;
      bus.in_rd = 11; bus.in_rd_wen = 1; bus.in_is_load = 1;
      bus.wb_valid = 1; bus.wb_rd_wen = 1; bus.wb_rd = 0; bus.wb_data = 64'hFF;
      tick();
      chk("x0_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("x0_a", bus.out_data_a, 64'd0);
      chk("x0_b", bus.out_data_b, 64'd0);

      // Flush during WAIT
      clear_in();
      bus.in_valid = 1; bus.in_rs1 = 11; bus.in_rd = 12;
      tick();
      chk("fl_wait_valid", {63'd0, bus.out_valid}, 64'd0);
      clear_in();
      bus.flush = 1;
      bus.wb_valid = 1; bus.wb_rd_wen = 1; bus.wb_rd = 11; bus.wb_data = 64'h44;
      tick();
      bus.flush = 0;
      clear_in();
      #1;
      chk("fl_wait_in_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
      chk("fl_wait_out_valid", {63'd0, bus.out_valid}, 64'd0);

      // Flush during a capture cycle
      bus.in_valid = 1; bus.in_rs1 = 3; bus.in_rs1_data = 64'h10;
      bus.flush = 1;
      #1;
      chk("fl_cap_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
      bus.flush = 0;
      clear_in();
      chk("fl_cap_out_valid", {63'd0, bus.out_valid}, 64'd0);

      // Async reset while READY
      bus.out_ready = 0;
      bus.in_valid = 1; bus.in_pc = 64'h40;
      bus.in_rs1 = 3; bus.in_rs1_data = 64'h10;
      bus.in_rs2 = 4; bus.in_rs2_data = 64'h20;
      bus.in_rd = 5; bus.in_rd_wen = 1; bus.in_aluctr = 2;
      tick();
      chk("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
      clear_in();
      #1;
      rst = 1;
      #1;
      chk("arst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("arst_a", bus.out_data_a, 64'd0);
      chk("arst_b", bus.out_data_b, 64'd0);
      chk("arst_pc", bus.out_pc, 64'd0);
      chk("arst_aluctr", {59'd0, bus.out_aluctr}, 64'd0);
      @(negedge clk);
      rst = 0;
      tick();
      chk("post_rst_valid", {63'd0, bus.out_valid}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
